// File: rtl/btn_conditioner.sv
// btn_conditioner: synchronizes, debounces and edge-detects eight active-low push buttons
module btn_conditioner #(
    parameter int DB_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] btn_sw_n,
    output logic [7:0] btn_level,
    output logic [7:0] btn_press,
    output logic [7:0] btn_release,
    output logic       any_press
);
    localparam int CW = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    logic [7:0]    sync1_q, sync2_q;
    logic [7:0]    state_q, state_d;
    logic [7:0]    press_q, press_d;
    logic [7:0]    release_q, release_d;
    logic [7:0]    differ, done;
    logic [CW-1:0] cnt_q [8];
    logic [CW-1:0] cnt_d [8];

    // per channel: count consecutive disagreeing samples, toggle the stable state on the last one
    always_comb begin
        differ    = '0;
        done      = '0;
        state_d   = state_q;
        press_d   = '0;
        release_d = '0;
        for (int i = 0; i < 8; i++) begin
            differ[i]    = ~sync2_q[i] ^ state_q[i];
            done[i]      = differ[i] && cnt_q[i] == CNT_MAX;
            cnt_d[i]     = (differ[i] && !done[i]) ? cnt_q[i] + CW'(1) : '0;
            state_d[i]   = state_q[i] ^ done[i];
            press_d[i]   = done[i] & ~state_q[i];
            release_d[i] = done[i] & state_q[i];
        end
    end

    // two-flop synchronizer and debounce state; sync flops reset to the released (high) level
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= '1;
            sync2_q   <= '1;
            state_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            for (int i = 0; i < 8; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q   <= btn_sw_n;
            sync2_q   <= sync1_q;
            state_q   <= state_d;
            press_q   <= press_d;
            release_q <= release_d;
            for (int i = 0; i < 8; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign btn_level   = state_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;
    assign any_press   = |press_q;
endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner: directed scenarios plus random bouncing against a run-length reference model
module tb_btn_conditioner;
    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] btn_sw_n = 8'hFF;
    logic [7:0] btn_level, btn_press, btn_release;
    logic       any_press;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] pipe [$];
    logic [7:0] m_level = '0, m_press = '0, m_release = '0;
    int         run [8];

    btn_conditioner #(.DB_CYCLES(DB)) dut (
        .clk(clk), .rst(rst), .btn_sw_n(btn_sw_n),
        .btn_level(btn_level), .btn_press(btn_press),
        .btn_release(btn_release), .any_press(any_press)
    );

    always #5 clk = ~clk;

    // drive one cycle, advance the reference model at the edge, settle 1 ns after it
    task automatic tick(input logic [7:0] raw, input logic r);
        logic [7:0] sample;
        btn_sw_n = raw;
        rst = r;
        @(posedge clk);
        m_press = '0;
        m_release = '0;
        if (r) begin
            pipe = '{8'hFF, 8'hFF};
            m_level = '0;
            for (int i = 0; i < 8; i++) run[i] = 0;
        end else begin
            sample = pipe.pop_front();
            pipe.push_back(raw);
            for (int i = 0; i < 8; i++) begin
                run[i] = ((!sample[i]) != m_level[i]) ? run[i] + 1 : 0;
                if (run[i] == DB) begin
                    m_level[i] = ~m_level[i];
                    m_press[i] = m_level[i];
                    m_release[i] = ~m_level[i];
                    run[i] = 0;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            tick(8'h00, 1'b1);
            vectors++;
            if ({btn_level, btn_press, btn_release, any_press} !== 25'd0) begin
                miscompares++;
                $display("FAIL reset: got lvl=%h prs=%h rel=%h any=%b want all zero",
                         btn_level, btn_press, btn_release, any_press);
            end
        end
    endtask

    task automatic test_clean_press();
        for (int k = 1; k <= 10; k++) begin
            tick(8'hFB, 1'b0);
            vectors++;
            if (btn_level !== (k >= 6 ? 8'h04 : 8'h00) || btn_press !== (k == 6 ? 8'h04 : 8'h00) ||
                any_press !== (k == 6) || btn_release !== 8'h00) begin
                miscompares++;
                $display("FAIL clean_press edge %0d: got lvl=%h prs=%h rel=%h any=%b", k,
                         btn_level, btn_press, btn_release, any_press);
            end
        end
    endtask

    task automatic test_release();
        for (int k = 1; k <= 10; k++) begin
            tick(8'hFF, 1'b0);
            vectors++;
            if (btn_level !== (k >= 6 ? 8'h00 : 8'h04) || btn_release !== (k == 6 ? 8'h04 : 8'h00) ||
                btn_press !== 8'h00 || any_press !== 1'b0) begin
                miscompares++;
                $display("FAIL release edge %0d: got lvl=%h prs=%h rel=%h any=%b", k,
                         btn_level, btn_press, btn_release, any_press);
            end
        end
    endtask

    task automatic test_bounce();
        logic [7:0] raw;
        for (int k = 1; k <= 14; k++) begin
            raw = (k == 4) ? 8'hFF : 8'hFE;
            tick(raw, 1'b0);
            vectors++;
            if (btn_press !== (k == 10 ? 8'h01 : 8'h00) || btn_level !== (k >= 10 ? 8'h01 : 8'h00) ||
                btn_release !== 8'h00) begin
                miscompares++;
                $display("FAIL bounce step %0d: got lvl=%h prs=%h rel=%h", k,
                         btn_level, btn_press, btn_release);
            end
        end
    endtask

    task automatic test_simultaneous();
        tick(8'hFF, 1'b1);
        tick(8'hFF, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            tick(8'hFC, 1'b0);
            vectors++;
            if (btn_press !== (k == 6 ? 8'h03 : 8'h00) || any_press !== (k == 6) ||
                btn_level !== (k >= 6 ? 8'h03 : 8'h00)) begin
                miscompares++;
                $display("FAIL simultaneous edge %0d: got lvl=%h prs=%h any=%b", k,
                         btn_level, btn_press, any_press);
            end
        end
    endtask

    task automatic test_reset_mid();
        tick(8'hFF, 1'b1);
        for (int k = 1; k <= 3; k++) begin
            tick(8'hF7, k == 3);
            vectors++;
            if ({btn_level, btn_press, btn_release} !== 24'd0) begin
                miscompares++;
                $display("FAIL reset_mid pre edge %0d: got lvl=%h prs=%h rel=%h", k,
                         btn_level, btn_press, btn_release);
            end
        end
        for (int k = 1; k <= 9; k++) begin
            tick(8'hF7, 1'b0);
            vectors++;
            if (btn_press !== (k == 6 ? 8'h08 : 8'h00) || btn_release !== 8'h00 ||
                btn_level !== (k >= 6 ? 8'h08 : 8'h00)) begin
                miscompares++;
                $display("FAIL reset_mid post edge %0d: got lvl=%h prs=%h rel=%h", k,
                         btn_level, btn_press, btn_release);
            end
        end
    endtask

    task automatic test_hold();
        int presses = 0;
        tick(8'hFF, 1'b1);
        for (int k = 1; k <= 100; k++) begin
            tick(8'h7F, 1'b0);
            presses += int'(btn_press[7]);
            vectors++;
            if (btn_level !== (k >= 6 ? 8'h80 : 8'h00) || btn_release !== 8'h00) begin
                miscompares++;
                $display("FAIL hold edge %0d: got lvl=%h rel=%h", k, btn_level, btn_release);
            end
        end
        vectors++;
        if (presses !== 1) begin
            miscompares++;
            $display("FAIL hold_count: got %0d press pulses want 1", presses);
        end
    endtask

    task automatic test_random();
        logic [7:0] target = 8'hFF;
        logic [7:0] noise;
        tick(8'hFF, 1'b1);
        for (int k = 0; k < 4000; k++) begin
            for (int i = 0; i < 8; i++) if ($urandom_range(0, 11) == 0) target[i] = ~target[i];
            noise = '0;
            for (int i = 0; i < 8; i++) noise[i] = ($urandom_range(0, 6) == 0);
            tick(target ^ noise, $urandom_range(0, 299) == 0);
            vectors++;
            if ({btn_level, btn_press, btn_release, any_press} !==
                {m_level, m_press, m_release, |m_press} || (btn_press & btn_release) !== 8'h00) begin
                miscompares++;
                $display("FAIL random cycle %0d: got lvl=%h prs=%h rel=%h any=%b want lvl=%h prs=%h rel=%h",
                         k, btn_level, btn_press, btn_release, any_press, m_level, m_press, m_release);
            end
        end
    endtask

    initial begin
        pipe = '{8'hFF, 8'hFF};
        for (int i = 0; i < 8; i++) run[i] = 0;
        test_reset();
        test_clean_press();
        test_release();
        test_bounce();
        test_simultaneous();
        test_reset_mid();
        test_hold();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/btn_conditioner.md
BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 Parameter DB_CYCLES, default 500000, SHALL set the number of consecutive clocks a synchronized level must persist to be accepted (10 ms at 50 MHz); legal values are >= 2.
REQ-002 clk  input  1  board clock; all state SHALL update on its rising edge; one clock domain.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 btn_sw_n  input  8  raw button switches, active-low (0 = pressed), asynchronous to clk, bouncing.
REQ-005 btn_level  output  8  debounced button state, active-high (1 = pressed).
REQ-006 btn_press  output  8  one-clock pulse per channel on each accepted press.
REQ-007 btn_release  output  8  one-clock pulse per channel on each accepted release.
REQ-008 any_press  output  1  OR of btn_press, same cycle.

Function
REQ-009 Each channel SHALL pass btn_sw_n[i] through a two-flop synchronizer before any other use.
REQ-010 Each channel SHALL hold a stable state (released/pressed) and a debounce counter wide enough for DB_CYCLES-1.
REQ-011 On an edge where the synchronized sample equals the stable state, the counter SHALL clear to 0.
REQ-012 On an edge where they differ and counter < DB_CYCLES-1, the counter SHALL increment by 1.
REQ-013 On an edge where they differ and counter == DB_CYCLES-1, the stable state SHALL toggle and the counter SHALL clear to 0.
REQ-014 Any single-cycle return to the stable level SHALL restart the qualification; no partial credit is kept.
REQ-015 Latency: a raw level held constant SHALL be reflected on btn_level at the (DB_CYCLES+2)th rising edge sampling it (first sampling edge counts as 1); with DB_CYCLES=4, the 6th edge.
REQ-016 btn_level[i] SHALL be 1 exactly when channel i stable state is pressed; it is registered, no combinational path from btn_sw_n.
REQ-017 btn_press[i] SHALL be high for exactly the one cycle in which btn_level[i] first reads 1 after being 0.
REQ-018 btn_release[i] SHALL be high for exactly the one cycle in which btn_level[i] first reads 0 after being 1.
REQ-019 btn_press[i] and btn_release[i] SHALL never be high in the same cycle; holding a button SHALL produce exactly one press pulse (no auto-repeat).
REQ-020 Channels SHALL be fully independent; simultaneous accepted events on several channels SHALL all pulse in the same cycle.
REQ-021 any_press SHALL be high in a cycle iff at least one btn_press bit is high.
REQ-022 Counters SHALL saturate by construction per REQ-013; no wrap-around past DB_CYCLES-1 is permitted.

Reset
REQ-023 While rst=1 at a clock edge: synchronizer flops SHALL load 1 (released), stable states released, counters 0.
REQ-024 Reset values: btn_level=8'h00, btn_press=8'h00, btn_release=8'h00, any_press=0.
REQ-025 Reset mid-qualification SHALL discard all counts; no press/release pulse SHALL be emitted for a transition interrupted by reset.
REQ-026 A button held pressed across reset deassertion SHALL be qualified from scratch and produce one btn_press pulse DB_CYCLES+2 edges after the first post-reset edge; no release pulse at reset.

Verification (DB_CYCLES=4)
REQ-027 Clean press: btn_sw_n[2] 1->0 held 10 cycles -> btn_level[2]=1 on 6th sampling edge, btn_press[2] and any_press high that single cycle, all other bits 0.
REQ-028 Bounce: btn_sw_n[0] low 3 cycles, high 1, low 10 -> no pulse during the first burst; btn_level[0]=1 on 6th edge after the final low begins, exactly one btn_press[0].
REQ-029 Release: after REQ-027, btn_sw_n[2] 0->1 -> btn_level[2]=0 on 6th edge, btn_release[2] one cycle, btn_press stays 8'h00.
REQ-030 Simultaneous: btn_sw_n 8'hFF->8'hFC on one edge -> btn_press=8'h03 for one cycle, any_press one cycle, btn_level=8'h03.
REQ-031 Reset mid-count: btn_sw_n[3] low, rst pulsed on 3rd sampling edge, input held low -> outputs 8'h00 during reset, btn_press[3] exactly once, 6 edges after first post-reset edge.
REQ-032 Hold: btn_sw_n[7] low 100 cycles -> exactly one btn_press[7] pulse, btn_level[7]=1 throughout after qualification.
